// File: rtl/moore_1011_pkg.sv
// Shared definitions for the 1011-preamble frame generator: state encoding and preamble pattern.
package moore_1011_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRE1    = 3'd1,
    PRE0    = 3'd2,
    PRE1B   = 3'd3,
    PRE1C   = 3'd4,
    PAYLOAD = 3'd5,
    GAP     = 3'd6
  } state_t;

  localparam logic [3:0] PREAMBLE = 4'b1011;

endpackage

// File: rtl/moore_1011_gen_piso_shift.sv
// Parallel-in serial-out register: loads a word, then presents it MSB first on head.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             head
);

  logic [WIDTH-1:0] shift_reg;

  // Load wins over shift; a shift moves the next bit into the MSB slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
    end else if (load) begin
      shift_reg <= data;
    end else if (shift) begin
      shift_reg <= shift_reg << 1;
    end
  end

  assign head = shift_reg[WIDTH-1];

endmodule

// File: rtl/moore_1011_gen.sv
// Moore frame generator: 1011 preamble, MSB-first payload, then idle-low gap, all outputs registered.
module moore_1011_gen
  import moore_1011_pkg::*;
#(
  parameter int PAYLOAD_W  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PAYLOAD_W-1:0] data_in,
  output logic                 sequence_out,
  output logic                 seq_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int MAX_CNT = (PAYLOAD_W > GAP_CYCLES) ? PAYLOAD_W : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             shift;
  logic             head;

  assign load  = (state == IDLE) && start;
  // The shifter advances as each payload bit is registered onto sequence_out.
  assign shift = (state == PRE1C) || ((state == PAYLOAD) && (cnt != '0));

  piso_shift #(.WIDTH(PAYLOAD_W)) u_piso (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .data  (data_in),
    .head  (head)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sequence_out <= 1'b0;
      seq_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= PRE1;
            sequence_out <= PREAMBLE[3];
            seq_valid    <= 1'b1;
            busy         <= 1'b1;
          end else begin
            sequence_out <= 1'b0;
            seq_valid    <= 1'b0;
            busy         <= 1'b0;
          end
        end
        PRE1: begin
          state        <= PRE0;
          sequence_out <= PREAMBLE[2];
        end
        PRE0: begin
          state        <= PRE1B;
          sequence_out <= PREAMBLE[1];
        end
        PRE1B: begin
          state        <= PRE1C;
          sequence_out <= PREAMBLE[0];
        end
        PRE1C: begin
          state        <= PAYLOAD;
          sequence_out <= head;
          cnt          <= CNT_W'(PAYLOAD_W - 1);
        end
        PAYLOAD: begin
          if (cnt == '0) begin
            state        <= GAP;
            sequence_out <= 1'b0;
            seq_valid    <= 1'b0;
            done         <= 1'b1;
            cnt          <= CNT_W'(GAP_CYCLES - 1);
          end else begin
            sequence_out <= head;
            cnt          <= cnt - 1'b1;
          end
        end
        GAP: begin
          done <= 1'b0;
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          cnt          <= '0;
          sequence_out <= 1'b0;
          seq_valid    <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/moore_1011_gen.md
MOORE_1011_GEN -- requirements
Module: moore_1011_gen

Interface
REQ-001 Parameter PAYLOAD_W, default 8: payload bits per frame (legal range 1..32).
REQ-002 Parameter GAP_CYCLES, default 2: idle-low cycles after each payload (legal range 1..15).
REQ-003 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  frame request, sampled on a rising clock edge only in IDLE.
REQ-006 Port data_in  input  PAYLOAD_W  payload, captured on the edge that accepts start.
REQ-007 Port sequence_out  output  1  serial bit stream.
REQ-008 Port seq_valid  output  1  high while sequence_out carries a preamble or payload bit.
REQ-009 Port busy  output  1  high from the cycle after start is accepted through the last gap cycle.
REQ-010 Port done  output  1  one-cycle pulse in the first gap cycle.

Function
REQ-011 The block SHALL be a Moore FSM; all outputs SHALL decode from registered state, shift register and counter only, never from inputs.
REQ-012 States: IDLE, PRE1, PRE0, PRE1B, PRE1C, PAYLOAD, GAP.
REQ-013 IDLE with start=1 at an edge -> PRE1 and data_in captured; IDLE with start=0 -> IDLE.
REQ-014 Preamble output 1,0,1,1 across PRE1, PRE0, PRE1B, PRE1C, one cycle each, seq_valid=1.
REQ-015 PAYLOAD: PAYLOAD_W cycles, captured word MSB first, seq_valid=1, bit counter counts down to 0, then -> GAP.
REQ-016 GAP: GAP_CYCLES cycles, sequence_out=0, seq_valid=0, done=1 in the first GAP cycle only; then -> IDLE.
REQ-017 Latency: the first preamble bit appears in the cycle immediately after the accepting edge; frame length is 4+PAYLOAD_W+GAP_CYCLES cycles.
REQ-018 start SHALL be ignored in all non-IDLE states; data_in changes during a frame SHALL NOT affect it.
REQ-019 With start held high continuously, frames SHALL run back-to-back with exactly one IDLE cycle between the last GAP cycle and the next PRE1.
REQ-020 IDLE outputs: sequence_out=0, seq_valid=0, busy=0, done=0.
REQ-021 Payload content is not filtered; a 1011 pattern inside the payload is transmitted unchanged.
REQ-022 Illegal state encodings SHALL return to IDLE on the next edge with all outputs at their idle values.

Reset
REQ-023 Reset asserted SHALL immediately force IDLE and set sequence_out, seq_valid, busy and done to 0, regardless of clock.
REQ-024 Reset asserted mid-frame SHALL abandon the frame; no done pulse is generated for it.
REQ-025 After reset release, the first accepted start is on the first rising edge with start=1.

Structure
REQ-026 Package moore_1011_pkg SHALL hold the state encoding constants and PREAMBLE = 4'b1011.
REQ-027 Sub-module piso_shift (parallel load, MSB-first shift, width PAYLOAD_W) is the one natural sub-module; the FSM and counters stay in the top.

Verification
REQ-028 Reset, start pulse with data_in=8'hA5: cycles 1-12 sequence_out=1,0,1,1,1,0,1,0,0,1,0,1 with seq_valid=1; cycle 13 done=1; busy low from cycle 15.
REQ-029 start pulsed again in cycle 5 of a frame with data_in=8'hFF: the frame is unchanged and no second frame starts.
REQ-030 start held high for 40 cycles with data_in=8'h00: PRE1 recurs every 15 cycles, with one done pulse per frame.
REQ-031 reset asserted between edges during PAYLOAD: outputs are 0 before the next edge, with no done pulse; a start after release gives a full frame.
REQ-032 Loopback into the 1011 Moore detector with payload 8'h00: detector_out is high for exactly one cycle per frame, the cycle after PRE1C.
REQ-033 Forced illegal state: one edge later state=IDLE and all outputs are 0.
